// File: rtl/pulse_capture_if.sv
// AXI4-Lite slave bus of pulse_capture. The address widens to 5 bits under
// PULSE_CAPTURE_EDGE_COUNT_EN so that the EDGES register at 0x10 is reachable.
interface pulse_capture_if;
`ifdef PULSE_CAPTURE_EDGE_COUNT_EN
  localparam int ADDR_W = 5;
`else
  localparam int ADDR_W = 4;
`endif
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [2:0]        AWPROT;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [2:0]        ARPROT;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  AWADDR, AWVALID, AWPROT, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARVALID, ARPROT, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport master (
    output AWADDR, AWVALID, AWPROT, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARVALID, ARPROT, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/pulse_capture.sv
// Pulse sample capture FIFO with AXI4-Lite register access (DATA/STATUS/CTRL/TOTAL).
// Optional EDGES rising-bit0 counter at 0x10 when PULSE_CAPTURE_EDGE_COUNT_EN is defined.
module pulse_capture #(
  parameter int FIFO_AW = 4
) (
  input  logic          S_AXI_ACLK,
  input  logic          S_AXI_ARESET,
  pulse_capture_if.slave axi,
  input  logic          S_AVST_VALID,
  input  logic [7:0]    S_AVST_DATA,
  output logic          S_AVST_READY
);
`ifdef PULSE_CAPTURE_EDGE_COUNT_EN
  localparam int ADDR_W = 5;
`else
  localparam int ADDR_W = 4;
`endif
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(4'h0);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4'h4);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(4'h8);
  localparam logic [ADDR_W-1:0] A_TOTAL  = ADDR_W'(4'hC);

  typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA, WRRESP} wstate_t;
  typedef enum logic [1:0] {RDRESET, RDIDLE, RDDATA} rstate_t;

  wstate_t           wstate_q, wstate_d;
  rstate_t           rstate_q, rstate_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [FIFO_AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic              enable_q, enable_d;
  logic              overflow_q, overflow_d;
  logic              clear_q, clear_d;
  logic [31:0]       total_q, total_d;
  logic [7:0]        mem_q [DEPTH];

  logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld, wr_en, rd_en, ctrl_wr;
  logic full, empty, push, pop;
  logic [FIFO_AW:0] level;
  logic [31:0] status, rd_mux;
  logic unused_ok;

  assign unused_ok = ^{axi.AWPROT, axi.ARPROT, axi.WDATA[31:2], axi.WSTRB[3:1]};

  // Pointers carry one extra wrap bit: equal => empty, only MSB differs => full.
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                  (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign level  = wptr_q - rptr_q;
  assign status = {16'b0, 8'(level), 5'b0, overflow_q, full, empty};

  assign S_AVST_READY = enable_q & ~full;
  assign push         = S_AVST_VALID & S_AVST_READY;
  assign pop          = rd_en && (axi.ARADDR == A_DATA) && !empty;
  assign ctrl_wr      = wr_en && (awaddr_q == A_CTRL) && axi.WSTRB[0];

`ifdef PULSE_CAPTURE_EDGE_COUNT_EN
  logic [31:0] edges_q, edges_d;
  logic        prev_bit_q, prev_bit_d;

  always_comb begin
    edges_d    = edges_q;
    prev_bit_d = prev_bit_q;
    if (push) begin
      prev_bit_d = S_AVST_DATA[0];
      if (S_AVST_DATA[0] && !prev_bit_q) edges_d = edges_q + 32'd1;
    end
    if (clear_q) begin
      edges_d    = 32'h0;
      prev_bit_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      edges_q    <= 32'h0;
      prev_bit_q <= 1'b0;
    end else begin
      edges_q    <= edges_d;
      prev_bit_q <= prev_bit_d;
    end
  end
`endif

  always_comb begin
    rd_mux = 32'h0;
    case (axi.ARADDR)
      A_DATA:   if (!empty) rd_mux = {23'b0, 1'b1, mem_q[rptr_q[FIFO_AW-1:0]]};
      A_STATUS: rd_mux = status;
      A_CTRL:   rd_mux = {31'b0, enable_q};
      A_TOTAL:  rd_mux = total_q;
`ifdef PULSE_CAPTURE_EDGE_COUNT_EN
      ADDR_W'(5'h10): rd_mux = edges_q;
`endif
      default:  rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    wstate_d = wstate_q;
    awaddr_d = awaddr_q;
    aw_rdy   = 1'b0;
    w_rdy    = 1'b0;
    b_vld    = 1'b0;
    wr_en    = 1'b0;
    case (wstate_q)
      WRIDLE: begin
        aw_rdy = 1'b1;
        if (axi.AWVALID) begin
          awaddr_d = axi.AWADDR;
          wstate_d = WRDATA;
        end
      end
      WRDATA: begin
        w_rdy = 1'b1;
        if (axi.WVALID) begin
          wr_en    = 1'b1;
          wstate_d = WRRESP;
        end
      end
      WRRESP: begin
        b_vld = 1'b1;
        if (axi.BREADY) wstate_d = WRIDLE;
      end
      default: wstate_d = WRIDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    ar_rdy   = 1'b0;
    r_vld    = 1'b0;
    rd_en    = 1'b0;
    case (rstate_q)
      RDIDLE: begin
        ar_rdy = 1'b1;
        if (axi.ARVALID) begin
          rd_en    = 1'b1;
          rdata_d  = rd_mux;
          rstate_d = RDDATA;
        end
      end
      RDDATA: begin
        r_vld = 1'b1;
        if (axi.RREADY) rstate_d = RDIDLE;
      end
      default: rstate_d = RDIDLE;
    endcase
  end

  // A CLEAR registered at the W handshake overrides this cycle's push/pop.
  always_comb begin
    wptr_d     = wptr_q + (FIFO_AW+1)'(push);
    rptr_d     = rptr_q + (FIFO_AW+1)'(pop);
    total_d    = total_q + 32'(push);
    overflow_d = overflow_q | (S_AVST_VALID & enable_q & full);
    enable_d   = ctrl_wr ? axi.WDATA[0] : enable_q;
    clear_d    = ctrl_wr & axi.WDATA[1];
    if (clear_q) begin
      wptr_d     = '0;
      rptr_d     = '0;
      total_d    = 32'h0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wstate_q   <= WRRESET;
      rstate_q   <= RDRESET;
      awaddr_q   <= '0;
      rdata_q    <= 32'h0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      clear_q    <= 1'b0;
      total_q    <= 32'h0;
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      awaddr_q   <= awaddr_d;
      rdata_q    <= rdata_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      clear_q    <= clear_d;
      total_q    <= total_d;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= S_AVST_DATA;
  end

  assign axi.AWREADY = aw_rdy;
  assign axi.WREADY  = w_rdy;
  assign axi.BVALID  = b_vld;
  assign axi.BRESP   = 2'b00;
  assign axi.ARREADY = ar_rdy;
  assign axi.RVALID  = r_vld;
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = 2'b00;
endmodule
